// File: rtl/zorro_busarb_pkg.sv
// zorro_busarb_pkg: arbiter state encodings, parameter defaults and the shared bus-idle term
package zorro_busarb_pkg;
  typedef enum logic [2:0] {
    ARB_IDLE, ARB_REQ, ARB_BACKOFF, ARB_WAITFREE, ARB_TAKE, ARB_MASTER, ARB_RELEASE, ARB_DROP
  } arb_state_e;
  localparam int REQ_TIMEOUT_DEF = 255;
  localparam int BACKOFF_DEF = 4;
  function automatic logic busfree(input logic fcs, input logic dtack, input logic slave, input logic zbgack);
    return !fcs && !dtack && !slave && !zbgack;
  endfunction
endpackage

// File: rtl/zorro_busarb_sync2.sv
// sync2: 1-bit two-flop synchronizer with synchronous reset to RST_VAL
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/zorro_busarb.sv
// zorro_busarb: Zorro III bus-mastership arbiter bridging the NCR 53C710 request to BR/BG/BGACK
module zorro_busarb
  import zorro_busarb_pkg::*;
#(
  parameter int REQ_TIMEOUT = REQ_TIMEOUT_DEF,
  parameter int BACKOFF = BACKOFF_DEF
) (
  input  logic clk,
  input  logic iorst,
  input  logic SCSI_BR_n,
  input  logic SCSI_BGACK_n,
  input  logic Z_BG_n,
  input  logic Z_BGACK_n,
  input  logic Z_FCS_n,
  input  logic DTACK_n,
  input  logic SLAVE_n,
  input  logic dma_efcs,
  output logic Z_BR_n,
  output logic bgack_drv,
  output logic OWN_n,
  output logic SCSI_BG_n,
  output logic mybus,
  output logic timeout
);
  logic [6:0] raw, syn;
  logic br, bgack, bg, zbgack, fcs, dtack, slave;
  assign raw = {SCSI_BR_n, SCSI_BGACK_n, Z_BG_n, Z_BGACK_n, Z_FCS_n, DTACK_n, SLAVE_n};
  for (genvar i = 0; i < 7; i++) begin : g_sync
    sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(iorst), .d(raw[i]), .q(syn[i]));
  end
  assign {br, bgack, bg, zbgack, fcs, dtack, slave} = ~syn;
  arb_state_e state, nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] bcnt, bcnt_nxt;
  logic rel_q, rel_now, to_nxt;
  assign rel_now = !br && !bgack;
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    bcnt_nxt = '0;
    to_nxt = 1'b0;
    case (state)
      ARB_IDLE: begin
        cnt_nxt = '0;
        nxt = br ? ARB_REQ : ARB_IDLE;
      end
      ARB_REQ:
        if (!br) nxt = ARB_IDLE;
        else if (bg) nxt = ARB_WAITFREE;
        else if (cnt == 8'(REQ_TIMEOUT)) begin
          to_nxt = 1'b1;
          nxt = ARB_BACKOFF;
        end else cnt_nxt = cnt + 8'(cnt != 8'hff);
      ARB_BACKOFF: begin
        bcnt_nxt = bcnt + 4'd1;
        nxt = (bcnt == 4'(BACKOFF - 1)) ? ARB_IDLE : ARB_BACKOFF;
      end
      ARB_WAITFREE: nxt = !br ? ARB_IDLE : !bg ? ARB_REQ :
                          busfree(fcs, dtack, slave, zbgack) ? ARB_TAKE : ARB_WAITFREE;
      ARB_TAKE: nxt = ARB_MASTER;
      ARB_MASTER: nxt = (rel_now && rel_q) ? ARB_RELEASE : ARB_MASTER;
      ARB_RELEASE: nxt = dma_efcs ? ARB_RELEASE : ARB_DROP;
      default: nxt = ARB_IDLE;
    endcase
  end
  // outputs are registered from the next state so they change on the transition edge
  always_ff @(posedge clk)
    if (iorst) begin
      state <= ARB_IDLE;
      cnt <= '0;
      bcnt <= '0;
      rel_q <= 1'b0;
      Z_BR_n <= 1'b1;
      bgack_drv <= 1'b0;
      OWN_n <= 1'b1;
      SCSI_BG_n <= 1'b1;
      mybus <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      bcnt <= bcnt_nxt;
      rel_q <= (state == ARB_MASTER) && rel_now;
      Z_BR_n <= !(nxt == ARB_REQ || nxt == ARB_WAITFREE);
      bgack_drv <= nxt inside {ARB_TAKE, ARB_MASTER, ARB_RELEASE};
      OWN_n <= !(nxt inside {ARB_TAKE, ARB_MASTER, ARB_RELEASE, ARB_DROP});
      SCSI_BG_n <= nxt != ARB_MASTER;
      mybus <= nxt == ARB_MASTER;
      timeout <= to_nxt;
    end
endmodule

// File: tb/tb_zorro_busarb.sv
// tb_zorro_busarb: randomized phase/latency checks of zorro_busarb against a timeline model
module tb_zorro_busarb;
  localparam int REQ_TO = 8;
  localparam int BOFF = 4;
  localparam int SYNC = 2;
  localparam int REQ_LAT = SYNC + 1;
  localparam int GRANT_LAT = SYNC + 3;
  localparam int REL_LAT = SYNC + 1 + 1;
  localparam int WD_LAT = SYNC + 1;
  localparam int TO_TICK = REQ_TO + 1;
  localparam int REREQ_TICK = TO_TICK + BOFF + 1;
  localparam logic [4:0] P_IDLE = 5'b10110, P_REQ = 5'b00110, P_TAKE = 5'b11010,
                         P_MASTER = 5'b11001, P_RELEASE = 5'b11010, P_DROP = 5'b10010;
  logic clk = 1'b0, iorst = 1'b1;
  logic SCSI_BR_n = 1'b1, SCSI_BGACK_n = 1'b1, Z_BG_n = 1'b1, Z_BGACK_n = 1'b1;
  logic Z_FCS_n = 1'b1, DTACK_n = 1'b1, SLAVE_n = 1'b1, dma_efcs = 1'b0;
  logic Z_BR_n, bgack_drv, OWN_n, SCSI_BG_n, mybus, timeout;
  int checks = 0, passes = 0;
  zorro_busarb #(.REQ_TIMEOUT(REQ_TO), .BACKOFF(BOFF)) dut (
    .clk(clk), .iorst(iorst), .SCSI_BR_n(SCSI_BR_n), .SCSI_BGACK_n(SCSI_BGACK_n),
    .Z_BG_n(Z_BG_n), .Z_BGACK_n(Z_BGACK_n), .Z_FCS_n(Z_FCS_n), .DTACK_n(DTACK_n),
    .SLAVE_n(SLAVE_n), .dma_efcs(dma_efcs), .Z_BR_n(Z_BR_n), .bgack_drv(bgack_drv),
    .OWN_n(OWN_n), .SCSI_BG_n(SCSI_BG_n), .mybus(mybus), .timeout(timeout)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [4:0] outs();
    return {Z_BR_n, bgack_drv, OWN_n, SCSI_BG_n, mybus};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go_request(output int n);
    SCSI_BR_n = 1'b0;
    n = 0;
    while (Z_BR_n !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
  endtask
  task automatic go_idle();
    int n;
    SCSI_BR_n = 1'b1;
    SCSI_BGACK_n = 1'b1;
    Z_BG_n = 1'b1;
    dma_efcs = 1'b0;
    {Z_FCS_n, DTACK_n, SLAVE_n, Z_BGACK_n} = 4'hf;
    n = 0;
    while (outs() !== P_IDLE && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) $display("FAIL return_to_idle: got %b want %b", outs(), P_IDLE);
    else passes++;
    repeat (4) tick();
  endtask
  task automatic test_reset();
    SCSI_BR_n = 1'b0;
    iorst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({outs(), timeout} !== {P_IDLE, 1'b0}) $display("FAIL reset_outputs: got %b want %b", {outs(), timeout}, {P_IDLE, 1'b0});
    else passes++;
    SCSI_BR_n = 1'b1;
    iorst = 1'b0;
    repeat (4) tick();
    checks++;
    if (outs() !== P_IDLE) $display("FAIL idle_after_reset: got %b want %b", outs(), P_IDLE);
    else passes++;
  endtask
  task automatic test_grant();
    int n, d, h;
    logic ok;
    d = $urandom_range(1, 4);
    h = $urandom_range(1, 6);
    go_request(n);
    checks++;
    if (n !== REQ_LAT) $display("FAIL req_latency: got %0d want %0d", n, REQ_LAT);
    else passes++;
    repeat (d) tick();
    Z_BG_n = 1'b0;
    n = 0;
    while (mybus !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == GRANT_LAT - 1) begin
        checks++;
        if (outs() !== P_TAKE) $display("FAIL take_phase: got %b want %b", outs(), P_TAKE);
        else passes++;
      end
    end
    checks++;
    if (n !== GRANT_LAT) $display("FAIL grant_latency: got %0d want %0d", n, GRANT_LAT);
    else passes++;
    checks++;
    if (outs() !== P_MASTER) $display("FAIL master_phase: got %b want %b", outs(), P_MASTER);
    else passes++;
    SCSI_BGACK_n = 1'b0;
    dma_efcs = 1'b1;
    repeat (3) tick();
    checks++;
    if (outs() !== P_MASTER) $display("FAIL master_hold: got %b want %b", outs(), P_MASTER);
    else passes++;
    SCSI_BR_n = 1'b1;
    SCSI_BGACK_n = 1'b1;
    Z_BG_n = 1'b1;
    n = 0;
    while (mybus !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== REL_LAT) $display("FAIL release_latency: got %0d want %0d", n, REL_LAT);
    else passes++;
    checks++;
    if (outs() !== P_RELEASE) $display("FAIL release_phase: got %b want %b", outs(), P_RELEASE);
    else passes++;
    ok = 1'b1;
    repeat (h) begin
      tick();
      if (outs() !== P_RELEASE) ok = 1'b0;
    end
    checks++;
    if (!ok) $display("FAIL release_hold: got %b want %b", outs(), P_RELEASE);
    else passes++;
    dma_efcs = 1'b0;
    tick();
    checks++;
    if (outs() !== P_DROP) $display("FAIL drop_phase: got %b want %b", outs(), P_DROP);
    else passes++;
    tick();
    checks++;
    if (outs() !== P_IDLE) $display("FAIL idle_after_drop: got %b want %b", outs(), P_IDLE);
    else passes++;
    repeat (4) tick();
  endtask
  task automatic test_busy();
    int n, b, sel;
    logic ok;
    b = $urandom_range(6, 12);
    sel = $urandom_range(0, 3);
    go_request(n);
    checks++;
    if (n !== REQ_LAT) $display("FAIL busy_req_latency: got %0d want %0d", n, REQ_LAT);
    else passes++;
    {Z_FCS_n, DTACK_n, SLAVE_n, Z_BGACK_n} = ~(4'b1000 >> sel);
    Z_BG_n = 1'b0;
    ok = 1'b1;
    repeat (b) begin
      tick();
      if (outs() !== P_REQ) ok = 1'b0;
    end
    checks++;
    if (!ok) $display("FAIL busy_wait sel=%0d: got %b want %b", sel, outs(), P_REQ);
    else passes++;
    {Z_FCS_n, DTACK_n, SLAVE_n, Z_BGACK_n} = 4'hf;
    repeat (SYNC) tick();
    checks++;
    if (outs() !== P_REQ) $display("FAIL busy_still_waiting: got %b want %b", outs(), P_REQ);
    else passes++;
    tick();
    checks++;
    if (outs() !== P_TAKE) $display("FAIL busy_take: got %b want %b", outs(), P_TAKE);
    else passes++;
    go_idle();
  endtask
  task automatic test_timeout();
    int n, pulses, first;
    logic ok;
    go_request(n);
    pulses = 0;
    first = -1;
    ok = 1'b1;
    for (int t = 1; t <= REREQ_TICK; t++) begin
      tick();
      if (timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = t;
      end
      if (t < TO_TICK && Z_BR_n !== 1'b0) ok = 1'b0;
      if (t >= TO_TICK && t < TO_TICK + BOFF && Z_BR_n !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (first !== TO_TICK) $display("FAIL timeout_tick: got %0d want %0d", first, TO_TICK);
    else passes++;
    checks++;
    if (pulses !== 1) $display("FAIL timeout_pulses: got %0d want 1", pulses);
    else passes++;
    checks++;
    if (!ok) $display("FAIL backoff_br: got %b want released for %0d cycles", Z_BR_n, BOFF);
    else passes++;
    checks++;
    if (Z_BR_n !== 1'b0) $display("FAIL rerequest: got %b want 0", Z_BR_n);
    else passes++;
    go_idle();
  endtask
  task automatic test_withdraw();
    int n, r;
    logic g, ok;
    r = $urandom_range(0, 4);
    g = 1'($urandom_range(0, 1));
    go_request(n);
    repeat (r) tick();
    SCSI_BR_n = 1'b1;
    Z_BG_n = !g;
    repeat (WD_LAT - 1) tick();
    checks++;
    if (outs() !== P_REQ) $display("FAIL withdraw_pending: got %b want %b", outs(), P_REQ);
    else passes++;
    tick();
    checks++;
    if (outs() !== P_IDLE) $display("FAIL withdraw_idle g=%0d: got %b want %b", g, outs(), P_IDLE);
    else passes++;
    ok = 1'b1;
    repeat (4) begin
      if (outs() !== P_IDLE || timeout !== 1'b0) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) $display("FAIL withdraw_stays_idle: got %b/%b want %b/0", outs(), timeout, P_IDLE);
    else passes++;
    Z_BG_n = 1'b1;
    repeat (3) tick();
  endtask
  task automatic test_reset_master();
    int n;
    go_request(n);
    Z_BG_n = 1'b0;
    n = 0;
    while (mybus !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (mybus !== 1'b1) $display("FAIL reach_master: got %b want 1", mybus);
    else passes++;
    iorst = 1'b1;
    tick();
    checks++;
    if ({outs(), timeout} !== {P_IDLE, 1'b0}) $display("FAIL reset_in_master: got %b want %b", {outs(), timeout}, {P_IDLE, 1'b0});
    else passes++;
    iorst = 1'b0;
    SCSI_BR_n = 1'b1;
    Z_BG_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (outs() !== P_IDLE) $display("FAIL idle_after_master_reset: got %b want %b", outs(), P_IDLE);
    else passes++;
  endtask
  initial begin
    test_reset();
    repeat (4) test_grant();
    repeat (3) test_busy();
    test_timeout();
    repeat (4) test_withdraw();
    test_reset_master();
    test_grant();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
